// File: rtl/spart_tx.sv
// spart_tx: transmit half of the SPART serial port.
// CPU bytes arrive through the IOW strobe into a DEPTH-entry FIFO. A bit-timed
// shifter then sends each byte on txd as 8N1: start bit, 8 data bits LSB first,
// stop bit.
// Optional: define SPART_TX_PARITY_EN to add an even-parity bit between the
// last data bit and the stop bit (8E1).
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous active-high reset
//   iow       write strobe; a byte is accepted when tx_full=0
//   tx_data   byte to write, sampled with iow
//   tx_full   FIFO holds DEPTH entries (registered)
//   tbr       transmit buffer ready, FIFO empty (registered)
//   busy      shifter is mid-frame (registered with the state)
//   overflow  sticky; set by iow while tx_full=1, cleared only by rst
//   txd       serial line, idles high (registered)
module spart_tx #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned BAUD_DIV = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       iow,
    input  logic [7:0] tx_data,
    output logic       tx_full,
    output logic       tbr,
    output logic       busy,
    output logic       overflow,
    output logic       txd
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam int unsigned BAUD_W = $clog2(BAUD_DIV);
    localparam logic [BAUD_W-1:0] BAUD_LOAD = BAUD_W'(BAUD_DIV - 1);

`ifdef SPART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;
`else
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;
`endif

    state_e            state_q, state_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [7:0]        shift_q, shift_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic              txd_q, txd_d;
    logic              busy_q, busy_d;
    logic              full_q, full_d;
    logic              tbr_q, tbr_d;
    logic              ovf_q, ovf_d;
`ifdef SPART_TX_PARITY_EN
    logic              parity_q, parity_d;
`endif
    logic [7:0]        mem_q [DEPTH];
    logic              wr_en, pop, bit_end;

    // Next-state, FIFO bookkeeping and registered-output values.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        txd_d     = txd_q;
        pop       = 1'b0;
`ifdef SPART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        wr_en     = iow && !full_q;
        bit_end   = (baud_q == '0);

        case (state_q)
            S_IDLE: begin
                txd_d = 1'b1;
                if (count_q != '0) begin
                    pop     = 1'b1;
                    state_d = S_START;
                    txd_d   = 1'b0;
                    baud_d  = BAUD_LOAD;
                    shift_d = mem_q[rd_ptr_q];
`ifdef SPART_TX_PARITY_EN
                    parity_d = ^mem_q[rd_ptr_q];
`endif
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d   = S_DATA;
                    txd_d     = shift_q[0];
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_idx_d = 3'd0;
                    baud_d    = BAUD_LOAD;
                end else begin
                    baud_d = baud_q - BAUD_W'(1);
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    baud_d = BAUD_LOAD;
                    if (bit_idx_q == 3'd7) begin
`ifdef SPART_TX_PARITY_EN
                        state_d = S_PARITY;
                        txd_d   = parity_q;
`else
                        state_d = S_STOP;
                        txd_d   = 1'b1;
`endif
                    end else begin
                        txd_d     = shift_q[0];
                        shift_d   = {1'b0, shift_q[7:1]};
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q - BAUD_W'(1);
                end
            end
`ifdef SPART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    txd_d   = 1'b1;
                    baud_d  = BAUD_LOAD;
                end else begin
                    baud_d = baud_q - BAUD_W'(1);
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    // Back-to-back frames: go straight to the next start bit.
                    if (count_q != '0) begin
                        pop     = 1'b1;
                        state_d = S_START;
                        txd_d   = 1'b0;
                        baud_d  = BAUD_LOAD;
                        shift_d = mem_q[rd_ptr_q];
`ifdef SPART_TX_PARITY_EN
                        parity_d = ^mem_q[rd_ptr_q];
`endif
                    end else begin
                        state_d = S_IDLE;
                        baud_d  = '0;
                    end
                end else begin
                    baud_d = baud_q - BAUD_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                txd_d   = 1'b1;
                baud_d  = '0;
            end
        endcase

        wr_ptr_d = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q + CNT_W'(wr_en) - CNT_W'(pop);
        full_d   = (count_d == CNT_W'(DEPTH));
        tbr_d    = (count_d == '0);
        busy_d   = (state_d != S_IDLE);
        ovf_d    = ovf_q | (iow & full_q);
    end

    // State and control registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            baud_q    <= '0;
            shift_q   <= '0;
            bit_idx_q <= '0;
            txd_q     <= 1'b1;
            busy_q    <= 1'b0;
            full_q    <= 1'b0;
            tbr_q     <= 1'b1;
            ovf_q     <= 1'b0;
`ifdef SPART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            baud_q    <= baud_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            txd_q     <= txd_d;
            busy_q    <= busy_d;
            full_q    <= full_d;
            tbr_q     <= tbr_d;
            ovf_q     <= ovf_d;
`ifdef SPART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    // FIFO storage; contents are only meaningful below the count, so no reset.
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            mem_q[wr_ptr_q] <= tx_data;
        end
    end

    assign txd      = txd_q;
    assign busy     = busy_q;
    assign tx_full  = full_q;
    assign tbr      = tbr_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_spart_tx.sv
// Scoreboard bench for spart_tx (DEPTH=4, BAUD_DIV=4). Accepted writes push the
// expected byte; a line monitor decodes txd frames and pops/compares.
module tb_spart_tx;

    localparam int BD = 4;
`ifdef SPART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       iow;
    logic [7:0] tx_data;
    logic       tx_full, tbr, busy, overflow, txd;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         busy_cnt = 0;
    int         nframes = 0;
    int         frame_start [64];
    logic [7:0] exp_q [$];

    spart_tx #(.DEPTH(4), .BAUD_DIV(BD)) dut (
        .clk      (clk),
        .rst      (rst),
        .iow      (iow),
        .tx_data  (tx_data),
        .tx_full  (tx_full),
        .tbr      (tbr),
        .busy     (busy),
        .overflow (overflow),
        .txd      (txd)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One-cycle write; scramble tx_data afterwards so late changes are visible.
    task automatic write(input logic [7:0] d, input bit accept);
        iow     = 1'b1;
        tx_data = d;
        tick();
        iow     = 1'b0;
        tx_data = ~d;
        if (accept) exp_q.push_back(d);
    endtask

    task automatic wait_idle(input int lim);
        int n = 0;
        while ((busy || !tbr) && n < lim) begin
            tick();
            n++;
        end
        check("idle_timeout", 32'({busy, tbr}), 32'b01);
    endtask

    // Line monitor: decodes frames by sampling mid-bit, compares against scoreboard.
    task automatic monitor();
        bit          active = 1'b0;
        int          mcnt = 0;
        logic [10:0] bits = '0;
        logic [7:0]  got;
        logic [7:0]  want;
        forever begin
            @(negedge clk);
            if (rst) begin
                active = 1'b0;
                exp_q.delete();
            end else begin
                if (busy) busy_cnt++;
                if (!active && !txd) begin
                    active = 1'b1;
                    mcnt   = 0;
                    if (nframes < 64) frame_start[nframes] = cyc;
                    nframes++;
                end
                if (active) begin
                    if (mcnt % BD == BD / 2) begin
                        bits[mcnt / BD] = txd;
                        if (mcnt / BD == NB - 1) begin
                            active = 1'b0;
                            got = bits[8:1];
                            check("mon_start_bit", 32'(bits[0]), 32'd0);
                            check("mon_stop_bit", 32'(bits[NB-1]), 32'd1);
`ifdef SPART_TX_PARITY_EN
                            check("mon_parity", 32'(bits[9]), 32'(^got));
`endif
                            if (exp_q.size() == 0) begin
                                check("mon_unexpected_frame", 32'(got), 32'h1ff);
                            end else begin
                                want = exp_q.pop_front();
                                check("mon_byte", 32'(got), 32'(want));
                            end
                        end
                    end
                    mcnt++;
                end
            end
        end
    endtask

    initial begin
        logic [10:0] fr;
        int b0, f0, n;
        rst     = 1'b1;
        iow     = 1'b0;
        tx_data = 8'h00;
        fork
            monitor();
        join_none

        // 1: reset state, then idle
        tick();
        check("reset_flags", 32'({txd, tbr, tx_full, busy, overflow}), 32'b11000);
        rst = 1'b0;
        repeat (50) begin
            tick();
            check("idle_flags", 32'({txd, tbr, tx_full, busy, overflow}), 32'b11000);
        end

        // 2: single byte A5, cycle-exact waveform
`ifdef SPART_TX_PARITY_EN
        fr = {1'b1, 1'b0, 8'hA5, 1'b0};
`else
        fr = {1'b1, 1'b1, 8'hA5, 1'b0};
`endif
        write(8'hA5, 1'b1);
        check("a5_tbr_after_write", 32'(tbr), 32'd0);
        check("a5_txd_before_start", 32'(txd), 32'd1);
        check("a5_busy_before_start", 32'(busy), 32'd0);
        for (int k = 1; k <= NB * BD; k++) begin
            tick();
            check("a5_txd_bit", 32'(txd), 32'(fr[(k - 1) / BD]));
            if (k == 1) begin
                check("a5_tbr_after_pop", 32'(tbr), 32'd1);
                check("a5_busy_rise", 32'(busy), 32'd1);
            end
        end
        tick();
        check("a5_busy_fall", 32'(busy), 32'd0);
        check("a5_txd_idle", 32'(txd), 32'd1);

        // 3: back-to-back burst; 01 is popped on the second write edge so count peaks at 3
        b0 = busy_cnt;
        f0 = nframes;
        write(8'h01, 1'b1);
        write(8'h02, 1'b1);
        write(8'h03, 1'b1);
        write(8'h04, 1'b1);
        check("burst_tx_full", 32'(tx_full), 32'd0);
        check("burst_tbr", 32'(tbr), 32'd0);
        wait_idle(400);
        check("burst_busy_cycles", 32'(busy_cnt - b0), 32'(4 * NB * BD));
        for (int k = 0; k < 3; k++)
            check("burst_frame_gap", 32'(frame_start[f0 + k + 1] - frame_start[f0 + k]), 32'(NB * BD));

        // 4: fill to full, overflow write dropped, slot freed by a pop
        write(8'h10, 1'b1);
        write(8'h11, 1'b1);
        write(8'h12, 1'b1);
        write(8'h13, 1'b1);
        write(8'h14, 1'b1);
        check("fill_tx_full", 32'(tx_full), 32'd1);
        check("fill_no_overflow", 32'(overflow), 32'd0);
        write(8'hFF, 1'b0);
        check("ovf_set", 32'(overflow), 32'd1);
        check("ovf_still_full", 32'(tx_full), 32'd1);
        n = 0;
        while (tx_full && n < 100) begin
            tick();
            n++;
        end
        check("ovf_slot_freed", 32'(tx_full), 32'd0);
        write(8'h15, 1'b1);
        check("ovf_refill_accepted", 32'(tx_full), 32'd1);
        wait_idle(600);
        check("ovf_sticky", 32'(overflow), 32'd1);

        // 5: reset during data bit 3 of 0F, then a clean frame
        write(8'h0F, 1'b1);
        repeat (18) tick();
        check("abort_busy_mid", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        check("abort_flags", 32'({txd, tbr, tx_full, busy, overflow}), 32'b11000);
        rst = 1'b0;
        tick();
        check("abort_txd_stays_high", 32'(txd), 32'd1);
        write(8'h55, 1'b1);
        wait_idle(200);

`ifdef SPART_TX_PARITY_EN
        // 6: parity bit values and 44-cycle frame
        write(8'h07, 1'b1);
        for (int k = 1; k <= 44; k++) begin
            tick();
            if (k == 38) check("par_07", 32'(txd), 32'd1);
            if (k == 42) check("par_07_stop", 32'(txd), 32'd1);
        end
        tick();
        check("par_07_frame_len", 32'(busy), 32'd0);
        write(8'h03, 1'b1);
        for (int k = 1; k <= 44; k++) begin
            tick();
            if (k == 38) check("par_03", 32'(txd), 32'd0);
        end
        wait_idle(100);
`endif

        repeat (4) tick();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
